// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: shifts a latched pattern out MSB first, a set number
// of times (or until stopped), with optional idle-zero gaps between repetitions.
module seq_pattern_gen #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  input  logic [CNT_W-1:0] gap,
  output logic             a,
  output logic             a_vld,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [CNT_W-1:0]   reps_q, reps_d;
  logic [CNT_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0]   bit_q, bit_d;
  logic               a_q, a_d;
  logic               a_vld_q, a_vld_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [IDX_W-1:0]   bit_dec;
  logic [CNT_W-1:0]   rep_nxt;
  logic               last_rep;

  assign bit_dec = bit_q - IDX_W'(1);
  assign rep_nxt = rep_cnt_q + CNT_W'(1);
  // reps==0 means continuous: the wrapping counter must never end the run
  assign last_rep = (reps_q != '0) && (rep_nxt == reps_q);

  // Next state and next registered outputs
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    reps_d    = reps_q;
    gap_d     = gap_q;
    rep_cnt_d = rep_cnt_q;
    gap_cnt_d = gap_cnt_q;
    bit_d     = bit_q;
    a_d       = 1'b0;
    a_vld_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          pat_d     = pattern;
          reps_d    = reps;
          gap_d     = gap;
          rep_cnt_d = '0;
          gap_cnt_d = '0;
          bit_d     = MSB_IDX;
          state_d   = S_SEND;
          a_d       = pattern[PAT_W-1];
          a_vld_d   = 1'b1;
          busy_d    = 1'b1;
        end
      end

      S_SEND: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (bit_q != '0) begin
          bit_d   = bit_dec;
          a_d     = pat_q[bit_dec];
          a_vld_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          rep_cnt_d = rep_nxt;
          if (last_rep) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (gap_q != '0) begin
            state_d   = S_GAP;
            gap_cnt_d = gap_q;
            busy_d    = 1'b1;
          end else begin
            bit_d   = MSB_IDX;
            a_d     = pat_q[PAT_W-1];
            a_vld_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end

      S_GAP: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q <= CNT_W'(1)) begin
          state_d   = S_SEND;
          gap_cnt_d = '0;
          bit_d     = MSB_IDX;
          a_d       = pat_q[PAT_W-1];
          a_vld_d   = 1'b1;
          busy_d    = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - CNT_W'(1);
          busy_d    = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      reps_q    <= '0;
      gap_q     <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
      bit_q     <= '0;
      a_q       <= 1'b0;
      a_vld_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      reps_q    <= reps_d;
      gap_q     <= gap_d;
      rep_cnt_q <= rep_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      bit_q     <= bit_d;
      a_q       <= a_d;
      a_vld_q   <= a_vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign a     = a_q;
  assign a_vld = a_vld_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: queue-based frame model checked every cycle, plus
// literal waveforms for the directed scenarios.
module tb_seq_pattern_gen;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [CNT_W-1:0] reps = '0;
  logic [CNT_W-1:0] gap = '0;
  logic             a, a_vld, busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .pattern(pattern), .reps(reps), .gap(gap),
    .a(a), .a_vld(a_vld), .busy(busy), .done(done)
  );

  // Model: each entry is the expected {a, a_vld, busy, done} for one cycle
  logic [3:0]       q[$];
  logic [3:0]       cur = 4'b0000;
  logic [PAT_W-1:0] m_pat = '0;
  logic [CNT_W-1:0] m_gap = '0;

  function automatic void push_rep(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] g,
                                   input bit with_gap);
    for (int i = PAT_W - 1; i >= 0; i--) q.push_back({p[i], 1'b1, 1'b1, 1'b0});
    if (with_gap) for (int j = 0; j < int'(g); j++) q.push_back(4'b0010);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      cur = 4'b0000;
    end else if (cur[1] == 1'b0 && cur[0] == 1'b0) begin
      if (start && !stop) begin
        m_pat = pattern;
        m_gap = gap;
        if (reps == '0) begin
          push_rep(pattern, gap, 1'b1);
        end else begin
          for (int r = 0; r < int'(reps); r++) push_rep(pattern, gap, r < int'(reps) - 1);
          q.push_back(4'b0001);
        end
        cur = q.pop_front();
      end else begin
        cur = 4'b0000;
      end
    end else if (cur[0]) begin
      cur = 4'b0000;
    end else if (stop) begin
      q.delete();
      cur = 4'b0000;
    end else begin
      if (q.size() == 0) push_rep(m_pat, m_gap, 1'b1);
      cur = q.pop_front();
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      total++;
      if ({a, a_vld, busy, done} !== cur) begin
        bad++;
        $display("FAIL model_cmp t=%0t got a/vld/busy/done=%b want %b",
                 $time, {a, a_vld, busy, done}, cur);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Start a frame, then record n cycles (cycle 1 lands at bit n-1)
  task automatic run(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] r,
                     input logic [CNT_W-1:0] g, input int n, input int stop_cyc,
                     input int dist_cyc, output logic [31:0] va, output logic [31:0] vv,
                     output logic [31:0] vb, output logic [31:0] vd);
    va = '0; vv = '0; vb = '0; vd = '0;
    @(negedge clk);
    pattern = p; reps = r; gap = g; start = 1'b1; stop = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      va = {va[30:0], a};
      vv = {vv[30:0], a_vld};
      vb = {vb[30:0], busy};
      vd = {vd[30:0], done};
      start = (i == dist_cyc);
      stop  = (i == stop_cyc);
      if (i == dist_cyc) begin
        pattern = ~p;
        reps    = r + CNT_W'(1);
        gap     = g + CNT_W'(1);
      end
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  logic [31:0] va, vv, vb, vd;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({a, a_vld, busy, done}), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // single repetition, no gap
    run(4'b1001, 4'd1, 4'd0, 6, 0, 0, va, vv, vb, vd);
    check("single_a", 32'(va[5:0]), 32'(6'b100100));
    check("single_vld", 32'(vv[5:0]), 32'(6'b111100));
    check("single_busy", 32'(vb[5:0]), 32'(6'b111100));
    check("single_done", 32'(vd[5:0]), 32'(6'b000010));

    // three repetitions with two-cycle gaps
    run(4'b1001, 4'd3, 4'd2, 18, 0, 0, va, vv, vb, vd);
    check("gap_a", 32'(va[17:0]), 32'({16'b1001001001001001, 2'b00}));
    check("gap_vld", 32'(vv[17:0]), 32'({16'b1111001111001111, 2'b00}));
    check("gap_busy", 32'(vb[17:0]), 32'({16'hFFFF, 2'b00}));
    check("gap_done", 32'(vd[17:0]), 32'd2);

    // continuous run aborted by stop in cycle 12
    run(4'b1000, 4'd0, 4'd1, 16, 12, 0, va, vv, vb, vd);
    check("cont_a", 32'(va[15:0]), 32'({12'b100001000010, 4'b0000}));
    check("cont_vld", 32'(vv[15:0]), 32'({12'b111101111011, 4'b0000}));
    check("cont_busy", 32'(vb[15:0]), 32'({12'hFFF, 4'b0000}));
    check("cont_done", 32'(vd[15:0]), 32'h0);

    // second start and new inputs mid-run have no effect
    run(4'b1001, 4'd2, 4'd0, 10, 0, 2, va, vv, vb, vd);
    check("dist_a", 32'(va[9:0]), 32'({8'b10011001, 2'b00}));
    check("dist_done", 32'(vd[9:0]), 32'd2);

    // start during a gap is ignored
    run(4'b0110, 4'd2, 4'd3, 13, 0, 5, va, vv, vb, vd);
    check("gapstart_a", 32'(va[12:0]), 32'({11'b01100000110, 2'b00}));
    check("gapstart_vld", 32'(vv[12:0]), 32'({11'b11110001111, 2'b00}));
    check("gapstart_done", 32'(vd[12:0]), 32'd2);

    // asynchronous reset between edges in cycle 3
    @(negedge clk);
    pattern = 4'b1001; reps = 4'd1; gap = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("async_rst", 32'({a, a_vld, busy, done}), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    vd = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vd = {vd[30:0], done};
    end
    check("no_done_after_rst", vd, 32'h0);
    run(4'b1001, 4'd1, 4'd0, 6, 0, 0, va, vv, vb, vd);
    check("post_rst_a", 32'(va[5:0]), 32'(6'b100100));
    check("post_rst_done", 32'(vd[5:0]), 32'(6'b000010));

    // start together with stop stays idle
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    vb = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vb = {vb[30:0], busy | a};
    end
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle", vb, 32'h0);

    // continuous run long enough to wrap the repetition counter
    run(4'b1010, 4'd0, 4'd0, 80, 70, 0, va, vv, vb, vd);
    check("wrap_a", va, {22'b1010101010101010101010, 10'b0});
    check("wrap_busy", vb, {22'h3FFFFF, 10'b0});
    check("wrap_done", vd, 32'h0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern length in bits (2..16).
REQ-002 SHALL have parameter CNT_W, default 4, width of the repeat and gap counts.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-006 SHALL have port stop  input  1  abort request; honoured in any non-IDLE state.
REQ-007 SHALL have port pattern  input  PAT_W  bit pattern to send, MSB first.
REQ-008 SHALL have port reps  input  CNT_W  number of pattern transmissions; 0 means continuous until stop.
REQ-009 SHALL have port gap  input  CNT_W  number of idle-zero cycles inserted between repetitions.
REQ-010 SHALL have port a  output  1  registered serial bit stream, the same stream format a sequence detector consumes.
REQ-011 SHALL have port a_vld  output  1  high while a carries a pattern bit; low during gap, idle and done.
REQ-012 SHALL have port busy  output  1  high in SEND and GAP states.
REQ-013 SHALL have port done  output  1  single-cycle pulse on normal completion.

Function
REQ-014 SHALL implement the states IDLE, SEND, GAP and DONE.
REQ-015 In IDLE, start=1 and stop=0 at a rising edge SHALL latch pattern, reps and gap into internal registers and enter SEND.
REQ-016 Input changes after the latch SHALL NOT affect the transmission in progress.
REQ-017 SEND SHALL drive a=pattern[PAT_W-1] in the first cycle after the start edge, then one lower bit per cycle, with a_vld=1 and busy=1, for PAT_W cycles.
REQ-018 After the LSB, the block SHALL enter GAP if repetitions remain and gap>0, re-enter SEND directly (MSB next cycle) if repetitions remain and gap=0, and enter DONE after the last repetition.
REQ-019 GAP SHALL last exactly gap cycles with a=0, a_vld=0 and busy=1, then return to SEND.
REQ-020 No gap SHALL follow the final repetition.
REQ-021 The repetition counter SHALL be CNT_W bits wide and count completed patterns.
REQ-022 With reps=0, the repetition counter SHALL NOT terminate the transmission; it wraps freely and only stop ends the run.
REQ-023 DONE SHALL last one cycle with done=1, busy=0, a=0 and a_vld=0, then return to IDLE.
REQ-024 stop=1 in SEND or GAP SHALL enter IDLE at that edge; a, a_vld and busy SHALL be 0 the next cycle and done SHALL NOT pulse.
REQ-025 start=1 and stop=1 together in IDLE SHALL leave the block in IDLE.
REQ-026 start while busy, or while in DONE, SHALL be ignored.
REQ-027 In IDLE, a, a_vld, busy and done SHALL all be 0.
REQ-028 a, a_vld, busy and done SHALL all be register outputs.

Reset
REQ-029 rst=0 SHALL immediately, without waiting for clk, force state IDLE, a=0, a_vld=0, busy=0, done=0, and clear all counters and latched registers.
REQ-030 Reset asserted mid-transmission SHALL discard the transmission; no done pulse SHALL follow reset release.
REQ-031 After rst returns to 1, the first start SHALL behave exactly as REQ-015.

Verification
REQ-032 pattern=1001, reps=1, gap=0, start pulse -> a=1,0,0,1 with a_vld=1 in cycles 1-4; done=1 in cycle 5; IDLE in cycle 6.
REQ-033 pattern=1001, reps=3, gap=2 -> a=1001 00 1001 00 1001 over 16 cycles; a_vld=0 on the four gap cycles; done in cycle 17.
REQ-034 pattern=1000, reps=0, gap=1, stop in cycle 12 -> repeating 1000 0 stream; a=a_vld=busy=0 from cycle 13; done never pulses.
REQ-035 Second start and a changed pattern applied in cycle 2 of a reps=2 run -> stream and done timing identical to an undisturbed run.
REQ-036 rst=0 asserted between clock edges in cycle 3 of a frame -> a, busy and a_vld drop at once; no done; a fresh start after release gives the REQ-032 waveform.
REQ-037 start=1 and stop=1 together in IDLE -> busy stays 0 and a stays 0 for 10 cycles.
